// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one fixed-latency single-ported memory between fetch (port 0) and load/store (port 1)
module mem_port_arbiter #(
  parameter int n = 32,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         req0,
  input  logic [n-1:0] addr0,
  input  logic         req1,
  input  logic [n-1:0] addr1,
  input  logic         we1,
  input  logic [n-1:0] wdata1,
  input  logic [n-1:0] memRdata,
  output logic         ack0,
  output logic         ack1,
  output logic [n-1:0] rdata,
  output logic         busy,
  output logic         muxSelect,
  output logic [n-1:0] memAddr,
  output logic [n-1:0] memWdata,
  output logic         memWe,
  output logic         memEn
);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic last_owner;
  logic grant;
  logic owner_req;
  // on a tie the port that did not win last time gets the memory
  assign grant = (req0 & req1) ? ~last_owner : req1;
  assign owner_req = muxSelect ? req1 : req0;
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      count      <= '0;
      last_owner <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
      muxSelect  <= 1'b0;
      memAddr    <= '0;
      memWdata   <= '0;
      memWe      <= 1'b0;
      memEn      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req0 | req1) begin
          state      <= ACCESS;
          muxSelect  <= grant;
          last_owner <= grant;
          memAddr    <= grant ? addr1 : addr0;
          memWdata   <= grant ? wdata1 : memWdata;
          memWe      <= grant & we1;
          memEn      <= 1'b1;
          busy       <= 1'b1;
          count      <= CW'(LATENCY - 1);
        end
        ACCESS: if (count == '0) begin
          state <= DONE;
          memEn <= 1'b0;
          memWe <= 1'b0;
          rdata <= memWe ? rdata : memRdata;
          ack0  <= ~muxSelect;
          ack1  <= muxSelect;
        end else begin
          count <= count - 1'b1;
        end
        DONE: if (!owner_req) begin
          state <= IDLE;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed reset/read/write checks, then randomized two-port traffic against a queue scoreboard
module tb_mem_port_arbiter;
  localparam int N = 32;
  localparam int L = 2;
  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        we;
  } tx_t;
  logic clk = 1'b0;
  logic nReset = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [N-1:0] addr0 = '0, addr1 = '0, wdata1 = '0;
  logic [N-1:0] memRdata, rdata, memAddr, memWdata, mem_word;
  logic ack0, ack1, busy, muxSelect, memWe, memEn;
  int checks = 0;
  int failures = 0;
  tx_t q0[$], q1[$];
  logic [31:0] wmem[8] = '{32'h00000077, 32'h01010178, 32'h02020279, 32'h0303037A,
                           32'h0404047B, 32'h0505057C, 32'h0606067D, 32'h0707077E};
  logic [31:0] p1_model[8] = '{32'h00000077, 32'h01010178, 32'h02020279, 32'h0303037A,
                               32'h0404047B, 32'h0505057C, 32'h0606067D, 32'h0707077E};
  int en_cnt = 0;
  logic mon_en = 1'b0;
  mem_port_arbiter #(.n(N), .LATENCY(L)) dut (
    .clk(clk), .nReset(nReset), .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .we1(we1), .wdata1(wdata1), .memRdata(memRdata), .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .busy(busy), .muxSelect(muxSelect), .memAddr(memAddr), .memWdata(memWdata),
    .memWe(memWe), .memEn(memEn)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5A5A5A);
  endfunction
  // memory returns good data only on the last enabled cycle of an access
  always_comb begin
    mem_word = memAddr[12] ? wmem[memAddr[4:2]] : rom(memAddr);
    memRdata = (memEn && en_cnt == L - 1) ? mem_word : 32'h0BAD0BAD;
  end
  always @(posedge clk) begin
    en_cnt <= memEn ? en_cnt + 1 : 0;
    if (memEn && memWe && memAddr[12]) wmem[memAddr[4:2]] <= memWdata;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic set_port(input int p, input logic r, input logic [31:0] a, input logic w, input logic [31:0] d);
    if (p == 0) begin
      req0 = r; addr0 = a;
    end else begin
      req1 = r; addr1 = a; we1 = w; wdata1 = d;
    end
  endtask
  task automatic drv(input int p, input int ntx);
    tx_t x;
    logic got, ab, pb, ackp;
    int idx;
    pb = p[0];
    for (int t = 0; t < ntx; t++) begin
      cyc($urandom_range(0, 2));
      if (p == 0) begin
        x.a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        x.we = 1'b0; x.wd = $urandom; x.rd = rom(x.a);
        q0.push_back(x);
      end else begin
        idx = $urandom_range(0, 7);
        x.a = 32'h1000 | (idx << 2);
        x.we = 1'($urandom_range(0, 1)); x.wd = $urandom;
        if (x.we) p1_model[idx] = x.wd;
        x.rd = p1_model[idx];
        q1.push_back(x);
      end
      set_port(p, 1'b1, x.a, x.we, x.wd);
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
        cyc(1);
        got = memEn && muxSelect == pb && !ack0 && !ack1;
      end
      chk($sformatf("accept_wait_p%0d", p), {31'd0, got}, 32'd1);
      if (!got) begin
        set_port(p, 1'b0, x.a, 1'b0, x.wd);
        return;
      end
      ab = $urandom_range(0, 3) == 0;
      set_port(p, !ab, $urandom, 1'($urandom_range(0, 1)), $urandom);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        ackp = pb ? ack1 : ack0;
        got = ackp;
        if (!got) cyc(1);
      end
      chk($sformatf("ack_wait_p%0d", p), {31'd0, got}, 32'd1);
      if (!ab) cyc($urandom_range(0, 5));
      set_port(p, 1'b0, x.a, 1'b0, x.wd);
      got = 1'b0;
      for (int i = 0; i < 5 && !got; i++) begin
        cyc(1);
        ackp = pb ? ack1 : ack0;
        got = !ackp;
      end
      chk($sformatf("ack_release_p%0d", p), {31'd0, got}, 32'd1);
    end
  endtask
  logic pr0 = 0, pr1 = 0, pa0 = 0, pa1 = 0, pen = 0, m_last = 1, mon_own = 0, exp_own;
  logic [31:0] model_rdata = 32'hDEADBEEF;
  int run = 0;
  tx_t h;
  always @(negedge clk) if (mon_en) begin
    if (ack0 || ack1) begin
      chk("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
      chk("ack_no_memen", {31'd0, memEn}, 32'd0);
    end
    if (memEn && !pen) begin
      exp_own = (pr0 && pr1) ? ~m_last : pr1;
      chk("grant_owner", {31'd0, muxSelect}, {31'd0, exp_own});
      m_last = exp_own;
      mon_own = exp_own;
      run = 1;
      if ((exp_own ? q1.size() : q0.size()) == 0) chk("accept_without_request", 32'd1, {31'd0, busy & 1'b0});
      else begin
        h = exp_own ? q1[0] : q0[0];
        chk("mem_addr", memAddr, h.a);
        chk("mem_we", {31'd0, memWe}, {31'd0, h.we});
        if (h.we) chk("mem_wdata", memWdata, h.wd);
      end
    end else if (memEn) run++;
    else if (pen) begin
      chk("memen_cycles", run, L);
      chk("ack_after_access", {31'd0, mon_own ? ack1 : ack0}, 32'd1);
    end
    if (ack0 && !pa0) begin
      if (q0.size() == 0) chk("ack0_without_request", 32'd1, {31'd0, busy & 1'b0});
      else begin
        h = q0.pop_front();
        model_rdata = h.rd;
        chk("rdata_p0", rdata, model_rdata);
      end
    end
    if (ack1 && !pa1) begin
      if (q1.size() == 0) chk("ack1_without_request", 32'd1, {31'd0, busy & 1'b0});
      else begin
        h = q1.pop_front();
        if (!h.we) model_rdata = h.rd;
        chk("rdata_p1", rdata, model_rdata);
      end
    end
    if (pa0) chk("ack0_4phase", {31'd0, ack0}, {31'd0, pr0});
    if (pa1) chk("ack1_4phase", {31'd0, ack1}, {31'd0, pr1});
    pr0 = req0; pr1 = req1; pa0 = ack0; pa1 = ack1; pen = memEn;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
  initial begin
    #12;
    chk("rst_ack0", {31'd0, ack0}, 32'd0);
    chk("rst_ack1", {31'd0, ack1}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_memen", {31'd0, memEn}, 32'd0);
    chk("rst_musel", {31'd0, muxSelect}, 32'd0);
    chk("rst_memaddr", memAddr, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    cyc(1);
    nReset = 1'b1;
    cyc(1);
    req0 = 1'b1; addr0 = 32'h40;
    cyc(1);
    chk("abort_memen_before", {31'd0, memEn}, 32'd1);
    #2 nReset = 1'b0;
    #1;
    chk("abort_memen", {31'd0, memEn}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ack0", {31'd0, ack0}, 32'd0);
    chk("abort_musel", {31'd0, muxSelect}, 32'd0);
    req0 = 1'b0;
    cyc(1);
    nReset = 1'b1;
    cyc(3);
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);
    chk("abort_idle_ack0", {31'd0, ack0}, 32'd0);
    req0 = 1'b1; addr0 = 32'h100;
    cyc(1);
    addr0 = 32'hFFFF;
    chk("rd_c1_memen", {31'd0, memEn}, 32'd1);
    chk("rd_c1_addr", memAddr, 32'h100);
    chk("rd_c1_we", {31'd0, memWe}, 32'd0);
    chk("rd_c1_musel", {31'd0, muxSelect}, 32'd0);
    chk("rd_c1_ack0", {31'd0, ack0}, 32'd0);
    cyc(1);
    chk("rd_c2_memen", {31'd0, memEn}, 32'd1);
    chk("rd_c2_ack0", {31'd0, ack0}, 32'd0);
    cyc(1);
    chk("rd_c3_memen", {31'd0, memEn}, 32'd0);
    chk("rd_c3_ack0", {31'd0, ack0}, 32'd1);
    chk("rd_c3_rdata", rdata, 32'hDEADBEEF);
    chk("rd_c3_busy", {31'd0, busy}, 32'd1);
    req0 = 1'b0;
    cyc(1);
    chk("rd_c4_ack0", {31'd0, ack0}, 32'd0);
    chk("rd_c4_busy", {31'd0, busy}, 32'd0);
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h200; wdata1 = 32'h12345678;
    cyc(1);
    chk("wr_c1_en", {31'd0, memEn}, 32'd1);
    chk("wr_c1_we", {31'd0, memWe}, 32'd1);
    chk("wr_c1_wdata", memWdata, 32'h12345678);
    chk("wr_c1_addr", memAddr, 32'h200);
    chk("wr_c1_musel", {31'd0, muxSelect}, 32'd1);
    cyc(1);
    chk("wr_c2_we", {31'd0, memWe & memEn}, 32'd1);
    cyc(1);
    chk("wr_c3_ack1", {31'd0, ack1}, 32'd1);
    chk("wr_c3_memwe", {31'd0, memWe | memEn}, 32'd0);
    chk("wr_c3_rdata", rdata, 32'hDEADBEEF);
    req1 = 1'b0; we1 = 1'b0;
    cyc(1);
    chk("wr_c4_ack1", {31'd0, ack1}, 32'd0);
    mon_en = 1'b1;
    fork
      drv(0, 30);
      drv(1, 30);
    join
    cyc(4);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
